// File: rtl/io_bridge_pkg.sv
// Shared definitions for the processor I/O bridge: default widths and the
// input-side handshake state encoding.
package io_bridge_pkg;
   localparam int DATA_W_DEF    = 16;
   localparam int OUT_DEPTH_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } in_state_t;
endpackage

// File: rtl/io_fifo.sv
// Circular output FIFO with an explicit occupancy counter; a push into a full
// FIFO is only accepted when a pop frees the head slot in the same cycle.
module io_fifo #(
   parameter int DATA_W    = 16,
   parameter int OUT_DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         rd_ready,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_valid,
   output logic [$clog2(OUT_DEPTH):0]   count,
   output logic                         drop
);
   localparam int PW = $clog2(OUT_DEPTH);

   logic [OUT_DEPTH-1:0][DATA_W-1:0] mem;
   logic [PW-1:0]                    rd_ptr, wr_ptr;
   logic [PW:0]                      cnt;
   logic                             full, push, pop;

   assign full     = (cnt == (PW+1)'(OUT_DEPTH));
   assign rd_valid = (cnt != '0);
   assign pop      = rd_valid & rd_ready;
   assign push     = wr_en & (~full | pop);
   assign drop     = wr_en & full & ~pop;
   assign rd_data  = mem[rd_ptr];
   assign count    = cnt;

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/io_bridge.sv
// Processor I/O bridge: buffered output port through io_fifo, single-word
// input hold register with a two-state handshake, and sticky error flags.
module io_bridge
   import io_bridge_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
   input  logic                         clock,
   input  logic                         rst,
   input  logic                         cpu_wr,
   input  logic [DATA_W-1:0]            cpu_wdata,
   input  logic                         cpu_rd,
   output logic [DATA_W-1:0]            cpu_rdata,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         in_avail,
   output logic [$clog2(OUT_DEPTH):0]   out_count,
   output logic                         ovf,
   output logic                         udf,
   input  logic                         clr_err
);
   in_state_t         state;
   logic [DATA_W-1:0] hold;
   logic              drop, udf_set;

   io_fifo #(.DATA_W(DATA_W), .OUT_DEPTH(OUT_DEPTH)) u_fifo (
      .clock    (clock),
      .rst      (rst),
      .wr_en    (cpu_wr),
      .wr_data  (cpu_wdata),
      .rd_ready (out_ready),
      .rd_data  (out_data),
      .rd_valid (out_valid),
      .count    (out_count),
      .drop     (drop)
   );

   assign in_ready  = (state == IDLE);
   assign in_avail  = (state == HOLD);
   assign cpu_rdata = hold;
   assign udf_set   = cpu_rd & (state == IDLE);

   // A word offered while the processor is consuming is refused; the hold
   // register keeps the consumed word until the next capture.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hold  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               hold  <= in_data;
               state <= HOLD;
            end
            HOLD: if (cpu_rd) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Set wins over a coincident clear.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (drop)         ovf <= 1'b1;
         else if (clr_err) ovf <= 1'b0;
         if (udf_set)      udf <= 1'b1;
         else if (clr_err) udf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_io_bridge;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clock = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_wr = 1'b0, cpu_rd = 1'b0, out_ready = 1'b0;
   logic          in_valid = 1'b0, clr_err = 1'b0;
   logic [DW-1:0] cpu_wdata = '0, in_data = '0;
   logic [DW-1:0] cpu_rdata, out_data;
   logic          out_valid, in_ready, in_avail, ovf, udf;
   logic [2:0]    out_count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_hold;
   bit            m_avail, m_ovf, m_udf;

   io_bridge #(.DATA_W(DW), .OUT_DEPTH(DEPTH)) dut (
      .clock     (clock),
      .rst       (rst),
      .cpu_wr    (cpu_wr),
      .cpu_wdata (cpu_wdata),
      .cpu_rd    (cpu_rd),
      .cpu_rdata (cpu_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_avail  (in_avail),
      .out_count (out_count),
      .ovf       (ovf),
      .udf       (udf),
      .clr_err   (clr_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO as a queue, input side as a held word plus a flag.
   always @(posedge clock or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_hold  = '0;
         m_avail = 1'b0;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
      end else begin
         bit did_pop, o_set, u_set;
         did_pop = (mq.size() != 0) && out_ready;
         o_set   = 1'b0;
         if (did_pop) void'(mq.pop_front());
         if (cpu_wr) begin
            if (mq.size() < DEPTH) mq.push_back(cpu_wdata);
            else o_set = 1'b1;
         end
         u_set = cpu_rd && !m_avail;
         if (m_avail) begin
            if (cpu_rd) m_avail = 1'b0;
         end else if (in_valid) begin
            m_avail = 1'b1;
            m_hold  = in_data;
         end
         m_ovf = o_set ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
         m_udf = u_set ? 1'b1 : (clr_err ? 1'b0 : m_udf);
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
         chk("out_count", 32'(out_count), 32'(mq.size()));
         if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
         chk("in_ready", 32'(in_ready), 32'(!m_avail));
         chk("in_avail", 32'(in_avail), 32'(m_avail));
         chk("cpu_rdata", 32'(cpu_rdata), 32'(m_hold));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("udf", 32'(udf), 32'(m_udf));
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
      cpu_wr   = 1'b0;
      cpu_rd   = 1'b0;
      in_valid = 1'b0;
      clr_err  = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] exp4 [4];
      exp4[0] = 16'h0002; exp4[1] = 16'h0003; exp4[2] = 16'h0004; exp4[3] = 16'h00AA;

      step(); step();
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst in_ready", 32'(in_ready), 1);
      chk("rst in_avail", 32'(in_avail), 0);
      chk("rst cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst out_count", 32'(out_count), 0);
      chk("rst flags", 32'({ovf, udf}), 0);
      chk_en = 1'b1;
      rst = 1'b0;

      // fill, then overflow
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cpu_wr = 1'b1; cpu_wdata = DW'(i);
         step();
      end
      chk("fill count", 32'(out_count), 4);
      chk("fill head", 32'(out_data), 32'h0001);
      cpu_wr = 1'b1; cpu_wdata = 16'h0005;
      step();
      chk("ovf set", 32'(ovf), 1);
      chk("ovf count", 32'(out_count), 4);

      // full + simultaneous pop accepts the store
      cpu_wr = 1'b1; cpu_wdata = 16'h00AA; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("full pushpop count", 32'(out_count), 4);
      for (int i = 0; i < 4; i++) begin
         chk("drain order", 32'(out_data), 32'(exp4[i]));
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
      chk("drain empty", 32'(out_count), 0);
      clr_err = 1'b1;
      step();
      chk("ovf clear", 32'(ovf), 0);

      // streaming across pointer wrap
      for (int k = 0; k < 6; k++) begin
         if (k > 0) chk("stream data", 32'(out_data), 32'(16'h0010 + k - 1));
         cpu_wr = 1'b1; cpu_wdata = DW'(16'h0010 + k); out_ready = 1'b1;
         step();
      end
      chk("stream count", 32'(out_count), 1);
      chk("stream last", 32'(out_data), 32'h0015);
      step();
      out_ready = 1'b0;
      chk("stream empty", 32'(out_count), 0);

      // input capture and refused same-cycle offer
      in_valid = 1'b1; in_data = 16'hBEEF;
      step();
      chk("cap rdata", 32'(cpu_rdata), 32'hBEEF);
      chk("cap avail", 32'(in_avail), 1);
      chk("cap ready", 32'(in_ready), 0);
      cpu_rd = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
      step();
      chk("consume avail", 32'(in_avail), 0);
      chk("consume keep", 32'(cpu_rdata), 32'hBEEF);
      in_valid = 1'b1; in_data = 16'h1234;
      step();
      chk("recap rdata", 32'(cpu_rdata), 32'h1234);
      cpu_rd = 1'b1;
      step();

      // underflow and clear priority
      cpu_rd = 1'b1;
      step();
      chk("udf set", 32'(udf), 1);
      chk("udf rdata", 32'(cpu_rdata), 32'h1234);
      clr_err = 1'b1;
      step();
      chk("udf clr", 32'(udf), 0);
      cpu_rd = 1'b1; clr_err = 1'b1;
      step();
      chk("udf set wins", 32'(udf), 1);
      clr_err = 1'b1;
      step();

      // async reset mid-transfer
      for (int i = 0; i < 3; i++) begin
         cpu_wr = 1'b1; cpu_wdata = DW'(16'h0100 + i);
         step();
      end
      in_valid = 1'b1; in_data = 16'hCAFE;
      step();
      #3 rst = 1'b1;
      #1;
      chk("arst out_valid", 32'(out_valid), 0);
      chk("arst in_ready", 32'(in_ready), 1);
      chk("arst rdata", 32'(cpu_rdata), 0);
      chk("arst count", 32'(out_count), 0);
      step();
      rst = 1'b0;
      cpu_wr = 1'b1; cpu_wdata = 16'h0077;
      step();
      chk("post-rst push", 32'(out_data), 32'h0077);
      chk("post-rst valid", 32'(out_valid), 1);

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         rst       = ($urandom_range(0, 199) == 0);
         cpu_wr    = $urandom_range(0, 1);
         cpu_wdata = DW'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         cpu_rd    = ($urandom_range(0, 2) == 0);
         in_valid  = $urandom_range(0, 1);
         in_data   = DW'($urandom);
         clr_err   = ($urandom_range(0, 7) == 0);
         step();
      end
      rst = 1'b0;
      step();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter DATA_W, default 16, word width of every data path.
REQ-002 Parameter OUT_DEPTH, default 4, output FIFO entry count (power of two, ≥2).
REQ-003 clock  in  1  single clock; every register updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cpu_wr  in  1  one-cycle strobe: processor stores cpu_wdata to the output port.
REQ-006 cpu_wdata  in  DATA_W  processor store data (the processor's write_out).
REQ-007 cpu_rd  in  1  one-cycle strobe: processor consumes the input word.
REQ-008 cpu_rdata  out  DATA_W  input word presented to the processor (feeds its read_in).
REQ-009 out_data  out  DATA_W  head of output FIFO toward the external device.
REQ-010 out_valid  out  1  out_data is valid.
REQ-011 out_ready  in  1  external device accepts out_data.
REQ-012 in_data  in  DATA_W  word from the external device.
REQ-013 in_valid  in  1  in_data is valid.
REQ-014 in_ready  out  1  block can capture in_data.
REQ-015 in_avail  out  1  an unconsumed input word is held.
REQ-016 out_count  out  $clog2(OUT_DEPTH)+1  current output FIFO occupancy.
REQ-017 ovf  out  1  sticky: a store was dropped because the FIFO was full.
REQ-018 udf  out  1  sticky: cpu_rd arrived with no input word held.
REQ-019 clr_err  in  1  synchronous clear of ovf and udf.

Function
REQ-020 Output FIFO SHALL be circular with rd/wr pointers wrapping modulo OUT_DEPTH and an explicit occupancy counter.
REQ-021 Push occurs when cpu_wr=1 and (out_count<OUT_DEPTH or a pop occurs in the same cycle).
REQ-022 Pop occurs when out_valid=1 and out_ready=1; out_valid = (out_count≠0); out_data = entry at rd pointer, combinational from storage.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance; when empty, push only (no write-through, first word visible one cycle after cpu_wr).
REQ-024 cpu_wr with FIFO full and no pop: data dropped, pointers and count unchanged, ovf set next cycle.
REQ-025 Input side SHALL be a two-state FSM: IDLE (in_ready=1, in_avail=0) and HOLD (in_ready=0, in_avail=1).
REQ-026 IDLE→HOLD when in_valid=1; in_data captured into the hold register that cycle; cpu_rdata shows it from the next cycle.
REQ-027 HOLD→IDLE when cpu_rd=1; a word offered by in_valid in that same cycle is not captured (in_ready=0) and is accepted no earlier than the following cycle.
REQ-028 cpu_rdata SHALL hold the last captured word after consumption until a new capture.
REQ-029 cpu_rd in IDLE: no state change, cpu_rdata unchanged, udf set next cycle.
REQ-030 clr_err=1 clears ovf and udf; a same-cycle set event takes priority over the clear.

Reset
REQ-031 On rst: pointers, out_count, ovf, udf, hold register = 0; FSM = IDLE; hence out_valid=0, in_ready=1, in_avail=0, cpu_rdata=0.
REQ-032 rst asserted mid-transfer discards all buffered words; FIFO storage contents need not be cleared.
REQ-033 First push/capture is accepted on the first rising edge after rst deasserts.

Structure
REQ-034 Shared package holds DATA_W default and the input FSM state enum {IDLE, HOLD}.
REQ-035 Output FIFO SHALL be one sub-module, io_fifo, parameterised by DATA_W and OUT_DEPTH; FSM and error flags live in io_bridge.

Verification
REQ-036 Four cpu_wr of 0x0001..0x0004, out_ready=0 -> out_count=4, out_data=0x0001; fifth cpu_wr 0x0005 -> dropped, ovf=1.
REQ-037 Full FIFO, cpu_wr 0x00AA with out_ready=1 same cycle -> count stays 4, 0x00AA read out as the last of the four after 0x0002..0x0004.
REQ-038 Six push/pop cycles past pointer wrap with out_ready=1 -> words emerge in order with no loss, out_count returns to 0.
REQ-039 in_valid with 0xBEEF in IDLE -> next cycle cpu_rdata=0xBEEF, in_avail=1, in_ready=0; cpu_rd plus in_valid 0x1234 same cycle -> 0x1234 captured one cycle later.
REQ-040 cpu_rd in IDLE -> udf=1; clr_err -> udf=0; clr_err with a coincident bad cpu_rd -> udf stays 1.
REQ-041 rst asserted with 3 words buffered and FSM in HOLD -> immediately out_valid=0, in_ready=1, cpu_rdata=0, out_count=0.
